// File: rtl/calc_pkg.sv
// Shared types and keymap for the keypad front end and the calculator FSM.
package calc_pkg;

   localparam logic [7:0] KEY_BS = 8'h08;

   typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_res_t;

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } db_state_t;

   // code = row*4 + col
   function automatic logic [7:0] key_to_char(input logic [3:0] code);
      logic [7:0] ch;
      case (code)
         4'd0:    ch = 8'h31;
         4'd1:    ch = 8'h32;
         4'd2:    ch = 8'h33;
         4'd3:    ch = 8'h2B;
         4'd4:    ch = 8'h34;
         4'd5:    ch = 8'h35;
         4'd6:    ch = 8'h36;
         4'd7:    ch = 8'h2D;
         4'd8:    ch = 8'h37;
         4'd9:    ch = 8'h38;
         4'd10:   ch = 8'h39;
         4'd11:   ch = 8'h2A;
         4'd12:   ch = 8'h43;
         4'd13:   ch = 8'h30;
         4'd14:   ch = 8'h3D;
         default: ch = KEY_BS;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key-event bus toward the calculator FSM.
interface keypad_scanner_if;
   import calc_pkg::*;

   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       btn_valid;
   logic [7:0] btn_char;
   logic       key_held;

   modport master (input row_n, output col_n, output btn_valid, output btn_char, output key_held);
   modport slave  (output row_n, input col_n, input btn_valid, input btn_char, input key_held);
endinterface

// File: rtl/keypad_scanner_frame_scan.sv
// Row synchronizer, column driver and per-frame hit accumulator (module kp_frame_scan).
module kp_frame_scan
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       frame_done_c,
   output frame_res_t frame_res_c,
   output logic [3:0] frame_code_c
);
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [3:0]    row_s1_q, row_s2_q;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_q, col_d;
   logic [1:0]    hits_q, hits_d;
   logic [3:0]    code_q, code_d;
   logic [3:0]    col_n_q, col_n_d;

   logic          sample_c;
   logic [2:0]    col_hits_c;
   logic [2:0]    total_c;
   logic [3:0]    col_code_c;

   always_comb begin
      sample_c   = (dwell_q == DWELL_LAST);
      col_hits_c = 3'd0;
      col_code_c = code_q;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2_q[r]) begin
            col_hits_c = col_hits_c + 3'd1;
            col_code_c = {2'(r), col_q};
         end
      end
      total_c = 3'(hits_q) + col_hits_c;

      frame_done_c = sample_c && (col_q == 2'd3);
      frame_code_c = col_code_c;
      if (total_c == 3'd0)      frame_res_c = FR_NONE;
      else if (total_c == 3'd1) frame_res_c = FR_SINGLE;
      else                      frame_res_c = FR_MULTI;

      dwell_d = sample_c ? '0 : dwell_q + DW'(1);
      col_d   = sample_c ? col_q + 2'd1 : col_q;
      col_n_d = ~(4'b0001 << col_d);
      hits_d  = hits_q;
      code_d  = code_q;
      if (sample_c) begin
         if (frame_done_c) begin
            hits_d = 2'd0;
            code_d = 4'd0;
         end else begin
            // saturate: anything above one hit is already a MULTI frame
            hits_d = (total_c >= 3'd2) ? 2'd2 : total_c[1:0];
            code_d = col_code_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         dwell_q  <= '0;
         col_q    <= 2'd0;
         hits_q   <= 2'd0;
         code_q   <= 4'd0;
         col_n_q  <= 4'b1110;
      end else begin
         row_s1_q <= row_n;
         row_s2_q <= row_s1_q;
         dwell_q  <= dwell_d;
         col_q    <= col_d;
         hits_q   <= hits_d;
         code_q   <= code_d;
         col_n_q  <= col_n_d;
      end
   end

   assign col_n = col_n_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: frame-level debounce FSM producing one-cycle key events.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 50000,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   keypad_scanner_if.master      kp
);
   localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_FRAMES);

   logic       frame_done_c;
   frame_res_t frame_res_c;
   logic [3:0] frame_code_c;

   kp_frame_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk          (clk),
      .rst          (rst),
      .row_n        (kp.row_n),
      .col_n        (kp.col_n),
      .frame_done_c (frame_done_c),
      .frame_res_c  (frame_res_c),
      .frame_code_c (frame_code_c)
   );

   db_state_t     state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          btn_valid_q, btn_valid_d;
   logic [7:0]    btn_char_q, btn_char_d;
   logic          key_held_q, key_held_d;
   logic          accept_c;
   logic [CW-1:0] cnt_inc_c;

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      btn_valid_d = 1'b0;
      btn_char_d  = btn_char_q;
      key_held_d  = key_held_q;
      accept_c    = 1'b0;
      cnt_inc_c   = cnt_q + CW'(1);

      if (frame_done_c) begin
         case (state_q)
            S_RELEASED: begin
               if (frame_res_c == FR_SINGLE) begin
                  cand_d = frame_code_c;
                  cnt_d  = CW'(1);
                  if (DEBOUNCE_FRAMES == 1) accept_c = 1'b1;
                  else                      state_d  = S_PRESS_WAIT;
               end
            end
            S_PRESS_WAIT: begin
               if (frame_res_c == FR_SINGLE) begin
                  if (frame_code_c == cand_q) begin
                     cnt_d = cnt_inc_c;
                     if (cnt_inc_c == CNT_TGT) accept_c = 1'b1;
                  end else begin
                     cand_d = frame_code_c;
                     cnt_d  = CW'(1);
                  end
               end else begin
                  state_d = S_RELEASED;
                  cnt_d   = '0;
               end
            end
            S_PRESSED: begin
               if (frame_res_c == FR_NONE) begin
                  if (DEBOUNCE_FRAMES == 1) begin
                     key_held_d = 1'b0;
                     state_d    = S_RELEASED;
                     cnt_d      = '0;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = S_RELEASE_WAIT;
                  end
               end
            end
            S_RELEASE_WAIT: begin
               if (frame_res_c == FR_NONE) begin
                  cnt_d = cnt_inc_c;
                  if (cnt_inc_c == CNT_TGT) begin
                     key_held_d = 1'b0;
                     state_d    = S_RELEASED;
                     cnt_d      = '0;
                  end
               end else begin
                  state_d = S_PRESSED;
                  cnt_d   = '0;
               end
            end
         endcase
      end

      if (accept_c) begin
         btn_valid_d = 1'b1;
         btn_char_d  = key_to_char(cand_d);
         key_held_d  = 1'b1;
         state_d     = S_PRESSED;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RELEASED;
         cand_q      <= 4'd0;
         cnt_q       <= '0;
         btn_valid_q <= 1'b0;
         btn_char_q  <= 8'h00;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         btn_valid_q <= btn_valid_d;
         btn_char_q  <= btn_char_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kp.btn_valid = btn_valid_q;
   assign kp.btn_char  = btn_char_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level reference model, stimulus table, corner sequences, random presses.
module tb_keypad_scanner;
   localparam int S  = 4;
   localparam int D  = 3;
   localparam int FR = 4 * S;

   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   logic [3:0]  row_drv;

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_FRAMES(D)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   // Passive membrane: a row is pulled low when a pressed key sits on the driven column.
   always_comb begin
      row_drv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.col_n[c] && pressed[r*4+c]) row_drv[r] = 1'b0;
   end
   assign kp.row_n = row_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] km [16] = '{8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h2D,
                           8'h37, 8'h38, 8'h39, 8'h2A, 8'h43, 8'h30, 8'h3D, 8'h08};

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;

   // reference model state
   int         mt;
   logic [3:0] d1, d2;
   int         hits, mcode;
   bit         mheld;
   int         run, rcode, nrun;
   logic       exp_valid;
   logic [7:0] exp_char;
   logic       exp_held;
   logic [3:0] exp_col;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Advance the model by one clock: rows seen by the scanner lag the pins by two cycles.
   task automatic model_step();
      int         col;
      logic [3:0] rows_now, seen;
      if (rst) begin
         mt = 0; d1 = 4'hF; d2 = 4'hF; hits = 0; mcode = 0;
         mheld = 0; run = 0; rcode = 0; nrun = 0;
         exp_valid = 0; exp_char = 8'h00;
      end else begin
         col = (mt / S) % 4;
         rows_now = 4'hF;
         for (int r = 0; r < 4; r++) if (pressed[r*4+col]) rows_now[r] = 1'b0;
         seen = d2;
         d2 = d1;
         d1 = rows_now;
         exp_valid = 0;
         if (mt % S == S - 1)
            for (int r = 0; r < 4; r++)
               if (!seen[r]) begin hits++; mcode = r*4 + col; end
         if (mt % FR == FR - 1) begin
            if (!mheld) begin
               if (hits == 1) begin
                  if (run > 0 && mcode == rcode) run++;
                  else begin run = 1; rcode = mcode; end
                  if (run == D) begin
                     exp_valid = 1; exp_char = km[rcode]; mheld = 1; run = 0; nrun = 0;
                  end
               end else run = 0;
            end else begin
               if (hits == 0) begin
                  nrun++;
                  if (nrun == D) begin mheld = 0; nrun = 0; end
               end else nrun = 0;
            end
            hits = 0;
         end
         mt++;
      end
      exp_held = mheld;
      exp_col  = ~(4'b0001 << ((mt / S) % 4));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("col_n", 8'(kp.col_n), 8'(exp_col));
      chk("btn_valid", 8'(kp.btn_valid), 8'(exp_valid));
      chk("btn_char", kp.btn_char, exp_char);
      chk("key_held", 8'(kp.key_held), 8'(exp_held));
      if (kp.btn_valid === 1'b1) pulses++;
   endtask

   task automatic hold(input logic [15:0] mask, input int ncyc);
      pressed = mask;
      repeat (ncyc) tick();
   endtask

   typedef struct {
      logic [15:0] mask;
      int          frames;
      int          npulse;
      logic [7:0]  chr;
      logic        held;
   } vec_t;

   vec_t tbl [21];

   initial begin
      int p0;
      tbl = '{
         '{16'h0000,  2, 0, 8'h00, 1'b0},
         '{16'h0040, 10, 1, 8'h36, 1'b1},
         '{16'h0000,  2, 0, 8'h36, 1'b1},
         '{16'h0000,  1, 0, 8'h36, 1'b0},
         '{16'h0003,  6, 0, 8'h36, 1'b0},
         '{16'h0001,  4, 1, 8'h31, 1'b1},
         '{16'h0000,  3, 0, 8'h31, 1'b0},
         '{16'h8000,  3, 1, 8'h08, 1'b1},
         '{16'h0000,  3, 0, 8'h08, 1'b0},
         '{16'h1000,  3, 1, 8'h43, 1'b1},
         '{16'h0000,  3, 0, 8'h43, 1'b0},
         '{16'h4000,  3, 1, 8'h3D, 1'b1},
         '{16'h0000,  3, 0, 8'h3D, 1'b0},
         '{16'h0800,  3, 1, 8'h2A, 1'b1},
         '{16'h0000,  3, 0, 8'h2A, 1'b0},
         '{16'h0008,  3, 1, 8'h2B, 1'b1},
         '{16'h0000,  1, 0, 8'h2B, 1'b1},
         '{16'h0008,  4, 0, 8'h2B, 1'b1},
         '{16'h0000,  3, 0, 8'h2B, 1'b0},
         '{16'h0200,  2, 0, 8'h2B, 1'b0},
         '{16'h0000,  3, 0, 8'h2B, 1'b0}
      };

      pressed = 16'h0000;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_col_n", 8'(kp.col_n), 8'h0E);
      chk("rst_btn_valid", 8'(kp.btn_valid), 8'h00);
      chk("rst_btn_char", kp.btn_char, 8'h00);
      chk("rst_key_held", 8'(kp.key_held), 8'h00);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         p0 = pulses;
         hold(tbl[i].mask, tbl[i].frames * FR);
         chk($sformatf("tbl%0d_pulses", i), 8'(pulses - p0), 8'(tbl[i].npulse));
         chk($sformatf("tbl%0d_char", i), kp.btn_char, tbl[i].chr);
         chk($sformatf("tbl%0d_held", i), 8'(kp.key_held), 8'(tbl[i].held));
      end

      // bounce on '5': alternating every 12 clk never gives three clean frames
      p0 = pulses;
      for (int k = 0; k < 4; k++) hold((k % 2 == 0) ? 16'h0020 : 16'h0000, 12);
      chk("bounce_pulses", 8'(pulses - p0), 8'd0);
      hold(16'h0020, 3 * FR);
      chk("bounce_settle_pulses", 8'(pulses - p0), 8'd1);
      chk("bounce_settle_char", kp.btn_char, 8'h35);
      hold(16'h0000, 3 * FR);
      chk("bounce_release_held", 8'(kp.key_held), 8'h00);

      // reset while '+' is held, then a fresh event for the same key
      p0 = pulses;
      hold(16'h0008, 3 * FR + 8);
      chk("pre_rst_pulses", 8'(pulses - p0), 8'd1);
      chk("pre_rst_held", 8'(kp.key_held), 8'h01);
      rst = 1'b1;
      tick();
      tick();
      chk("mid_rst_held", 8'(kp.key_held), 8'h00);
      chk("mid_rst_char", kp.btn_char, 8'h00);
      chk("mid_rst_col_n", 8'(kp.col_n), 8'h0E);
      rst = 1'b0;
      p0 = pulses;
      hold(16'h0008, 3 * FR);
      chk("post_rst_pulses", 8'(pulses - p0), 8'd1);
      chk("post_rst_char", kp.btn_char, 8'h2B);
      hold(16'h0000, 4 * FR);

      // random presses, unaligned to frames, checked cycle by cycle by the model
      for (int s = 0; s < 150; s++) begin
         int          kind;
         logic [15:0] m;
         kind = $urandom_range(0, 3);
         m = 16'h0000;
         if (kind == 1 || kind == 2) m[$urandom_range(0, 15)] = 1'b1;
         if (kind == 3) begin
            m[$urandom_range(0, 15)] = 1'b1;
            m[$urandom_range(0, 15)] = 1'b1;
         end
         hold(m, $urandom_range(3, 70));
      end
      hold(16'h0000, 4 * FR);
      chk("final_held", 8'(kp.key_held), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
